// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready word stream leaving the FIFO read stage.
//   m_valid - word present on m_data/m_last
//   m_ready - consumer accepts the word this cycle
//   m_data  - DSIZE-bit word
//   m_last  - word closes a burst
// master = producer (fifo_rd_stream), slave = consumer.
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer sitting right after the async FIFO.
// Pulls words through the FIFO read port into a 2-entry head/skid buffer and
// re-presents them as a valid/ready stream. Every BURST_LEN-th word pulled
// is tagged m_last. A flush empties this stage and pulses fifo_rptr_clr the
// following cycle so the FIFO read pointer is cleared too.
//   clk, rst       - read-domain clock, async active-high reset
//   en             - allow new FIFO reads (buffered words drain regardless)
//   flush          - synchronous clear request
//   fifo_empty     - FIFO empty flag
//   fifo_rdata     - FIFO read data (async read, valid while non-empty)
//   fifo_ren       - FIFO pointer advance; word captured on the same edge
//   fifo_rptr_clr  - registered copy of flush, clears the FIFO read pointer
//   m              - output stream (master side)
//   occ            - buffer occupancy 0..2
module fifo_rd_stream #(
    parameter int DSIZE     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             fifo_rptr_clr,
    fifo_rd_stream_if.master m,
    output logic [1:0]       occ
);
    localparam int            CW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

    // Occupancy doubles as the buffer state.
    localparam logic [1:0] OCC0 = 2'd0;
    localparam logic [1:0] OCC1 = 2'd1;
    localparam logic [1:0] OCC2 = 2'd2;

    typedef struct packed {
        logic             last;
        logic [DSIZE-1:0] data;
    } entry_t;

    entry_t        h;        // head: the word on the output
    entry_t        s;        // skid: second word, only valid at occ==2
    entry_t        new_ent;
    logic [CW-1:0] cnt;
    logic          cnt_wrap;
    logic          push;
    logic          pop;

    assign cnt_wrap = (cnt == CNT_LAST);
    assign new_ent  = {cnt_wrap, fifo_rdata};

    // Read decision uses only local registers and the FIFO flag, so there is
    // no combinational path from m_ready to the FIFO pointer. Reset also
    // blocks reads so nothing is pulled while the stage is held clear.
    assign fifo_ren = ~rst & en & ~fifo_empty & (occ != OCC2) & ~flush & ~fifo_rptr_clr;
    assign push     = fifo_ren;
    assign pop      = m.m_valid & m.m_ready;

    assign m.m_valid = (occ != OCC0);
    assign m.m_data  = h.data;
    assign m.m_last  = h.last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ           <= OCC0;
            h             <= '0;
            s             <= '0;
            cnt           <= '0;
            fifo_rptr_clr <= 1'b0;
        end else begin
            fifo_rptr_clr <= flush;
            if (flush) begin
                // A pop in this cycle still completes; buffered words go away.
                occ <= OCC0;
                cnt <= '0;
                h   <= '0;
                s   <= '0;
            end else begin
                // Burst position tracks words pulled, not words delivered.
                if (push)
                    cnt <= cnt_wrap ? '0 : cnt + CW'(1);
                case (occ)
                    OCC0: if (push) begin
                        h   <= new_ent;
                        occ <= OCC1;
                    end
                    OCC1: begin
                        if (push && pop) begin
                            h <= new_ent;
                        end else if (push) begin
                            s   <= new_ent;
                            occ <= OCC2;
                        end else if (pop) begin
                            occ <= OCC0;
                        end
                    end
                    OCC2: if (pop) begin
                        // push is impossible here, so the skid just moves up
                        h   <= s;
                        occ <= OCC1;
                    end
                    default: occ <= OCC0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    localparam int DSIZE = 8;
    localparam int BL    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic             fifo_empty;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_ren;
    logic             fifo_rptr_clr;
    logic [1:0]       occ;

    fifo_rd_stream_if #(.DSIZE(DSIZE)) mif ();

    fifo_rd_stream #(.DSIZE(DSIZE), .BURST_LEN(BL)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_ren      (fifo_ren),
        .fifo_rptr_clr (fifo_rptr_clr),
        .m             (mif),
        .occ           (occ)
    );

    always #5 clk = ~clk;

    // FIFO model: array with free-running indices.
    logic [DSIZE-1:0] mem [64];
    int               wr_i = 0;
    int               rd_i = 0;
    assign fifo_empty = (wr_i == rd_i);
    assign fifo_rdata = mem[rd_i[5:0]];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [DSIZE-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_i[5:0]] = base + DSIZE'(i);
            wr_i = wr_i + 1;
        end
    endtask

    // Scoreboard: expected {last,data} queued when a read is issued,
    // compared when the stream transfers a word.
    logic [DSIZE:0] exp_q [$];
    int             mcnt    = 0;
    int             ren_cnt = 0;
    int             vld_cnt = 0;
    logic           ren_s   = 1'b0;
    logic           clr_s   = 1'b0;

    always @(negedge clk) begin
        logic [DSIZE:0] e;
        ren_s = fifo_ren;
        clr_s = fifo_rptr_clr;
        if (rst) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            if (mif.m_valid) vld_cnt++;
            if (mif.m_valid && mif.m_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(mif.m_data), 32'(e[DSIZE-1:0]));
                    chk("sb_last", 32'(mif.m_last), 32'(e[DSIZE]));
                end
            end
            if (flush) begin
                exp_q.delete();
                mcnt = 0;
            end else if (fifo_ren) begin
                ren_cnt++;
                exp_q.push_back({(mcnt == BL - 1), fifo_rdata});
                mcnt = (mcnt == BL - 1) ? 0 : mcnt + 1;
            end
        end
    end

    // FIFO pointer moves on the edge the DUT captures the word.
    always @(posedge clk) begin
        if (ren_s) rd_i <= rd_i + 1;
        else if (clr_s) rd_i <= wr_i;
    end

    initial begin
        rst = 1'b0; en = 1'b0; flush = 1'b0; mif.m_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_occ",   32'(occ), 32'd0);
        chk("rst_vld",   32'(mif.m_valid), 32'd0);
        chk("rst_data",  32'(mif.m_data), 32'd0);
        chk("rst_last",  32'(mif.m_last), 32'd0);
        chk("rst_ren",   32'(fifo_ren), 32'd0);
        chk("rst_clr",   32'(fifo_rptr_clr), 32'd0);
        tick(2);
        rst = 1'b0;

        // Streaming: 8 words, one per cycle
        tick();
        load(8, 8'h10); mif.m_ready = 1'b1; en = 1'b1; ren_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("st_ren", 32'(fifo_ren), 32'(k < 8));
            chk("st_vld", 32'(mif.m_valid), 32'(k >= 1 && k <= 8));
        end
        tick();
        chk("st_ren_cnt", 32'(ren_cnt), 32'd8);

        // Backpressure: 5 words, consumer stalled
        mif.m_ready = 1'b0; load(5, 8'h20); ren_cnt = 0;
        repeat (6) @(negedge clk);
        tick();
        chk("bp_ren_cnt", 32'(ren_cnt), 32'd2);
        chk("bp_occ",     32'(occ), 32'd2);
        chk("bp_data",    32'(mif.m_data), 32'h20);
        chk("bp_vld",     32'(mif.m_valid), 32'd1);
        mif.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_ren_full", 32'(fifo_ren), 32'd0);
        @(negedge clk);
        chk("bp_resume", 32'(fifo_ren), 32'd1);
        tick(8);
        chk("bp_drain_occ", 32'(occ), 32'd0);
        chk("bp_ren_total", 32'(ren_cnt), 32'd5);

        // Empty boundary: one word, then a long empty stretch
        ren_cnt = 0; vld_cnt = 0;
        load(1, 8'h30);
        tick(3);
        chk("em_ren", 32'(ren_cnt), 32'd1);
        chk("em_vld", 32'(vld_cnt), 32'd1);
        chk("em_occ", 32'(occ), 32'd0);
        ren_cnt = 0;
        tick(20);
        chk("em_idle", 32'(ren_cnt), 32'd0);

        // en gating: fill, drop en, drain, raise en
        mif.m_ready = 1'b0; load(6, 8'h50);
        tick(4);
        chk("eg_occ_full", 32'(occ), 32'd2);
        en = 1'b0; mif.m_ready = 1'b1; ren_cnt = 0;
        tick(4);
        chk("eg_no_ren", 32'(ren_cnt), 32'd0);
        chk("eg_drain",  32'(occ), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("eg_ren_same", 32'(fifo_ren), 32'd1);
        tick(6);
        chk("eg_occ_end", 32'(occ), 32'd0);
        chk("eg_ren_cnt", 32'(ren_cnt), 32'd4);

        // Flush with occ=2 and burst counter at 2
        mif.m_ready = 1'b0; load(4, 8'h40);
        tick(4);
        chk("fl_pre_occ", 32'(occ), 32'd2);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_ren0", 32'(fifo_ren), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_occ", 32'(occ), 32'd0);
        chk("fl_vld", 32'(mif.m_valid), 32'd0);
        chk("fl_clr", 32'(fifo_rptr_clr), 32'd1);
        @(negedge clk);
        chk("fl_ren1", 32'(fifo_ren), 32'd0);
        tick();
        chk("fl_clr_off", 32'(fifo_rptr_clr), 32'd0);
        load(4, 8'h60); mif.m_ready = 1'b1;
        tick(7);
        chk("fl_drain", 32'(occ), 32'd0);

        // Async reset mid-stream with occ=2
        mif.m_ready = 1'b0; load(5, 8'h70);
        tick(4);
        chk("rs_pre_occ", 32'(occ), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("rs_occ",  32'(occ), 32'd0);
        chk("rs_vld",  32'(mif.m_valid), 32'd0);
        chk("rs_data", 32'(mif.m_data), 32'd0);
        chk("rs_last", 32'(mif.m_last), 32'd0);
        chk("rs_ren",  32'(fifo_ren), 32'd0);
        chk("rs_clr",  32'(fifo_rptr_clr), 32'd0);
        tick();
        rst = 1'b0;
        mif.m_ready = 1'b1; load(1, 8'h75);
        tick(8);
        chk("rs_drain", 32'(occ), 32'd0);
        chk("sb_left",  32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
